// File: rtl/uc_multiciclo_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU command codes,
// flag bit positions, FSM state encoding and the branch-condition helper.
package uc_multiciclo_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam int FLAG_ZERO = 0;
   localparam int FLAG_MSB  = 1;
   localparam int FLAG_OVF  = 2;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
      S_LD_WB, S_MEM_WR, S_BRANCH, S_JAL, S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      ALU_OP_ADD, ALU_OP_R, ALU_OP_I, ALU_OP_BR
   } alu_op_t;

   // Signed less-than after a subtract is MSB xor overflow.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic [2:0] flags);
      logic lt;
      lt = flags[FLAG_MSB] ^ flags[FLAG_OVF];
      case (funct3)
         3'b000:  branch_taken = flags[FLAG_ZERO];
         3'b001:  branch_taken = !flags[FLAG_ZERO];
         3'b100:  branch_taken = lt;
         3'b101:  branch_taken = !lt;
         default: branch_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uc_alu_decoder.sv
// Combinational ALU command decoder: maps funct fields and the instruction class
// to an ALU command, flagging funct encodings the unit does not support.
module uc_alu_decoder
   import uc_multiciclo_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic [1:0] alu_op,
   output logic [3:0] alu_cmd,
   output logic       bad_funct
);

   always_comb begin
      alu_cmd   = ALU_ADD;
      bad_funct = 1'b0;
      case (alu_op)
         ALU_OP_R: begin
            case ({funct3, funct7_5})
               4'b000_0: alu_cmd = ALU_ADD;
               4'b000_1: alu_cmd = ALU_SUB;
               4'b111_0: alu_cmd = ALU_AND;
               4'b110_0: alu_cmd = ALU_OR;
               default:  bad_funct = 1'b1;
            endcase
         end
         ALU_OP_I: begin
            case (funct3)
               3'b000:  alu_cmd = ALU_ADD;
               3'b111:  alu_cmd = ALU_AND;
               3'b110:  alu_cmd = ALU_OR;
               default: bad_funct = 1'b1;
            endcase
         end
         ALU_OP_BR: begin
            alu_cmd = ALU_SUB;
            case (funct3)
               3'b000, 3'b001, 3'b100, 3'b101: bad_funct = 1'b0;
               default:                        bad_funct = 1'b1;
            endcase
         end
         default: alu_cmd = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: one instruction at a time through FETCH/DECODE/execute
// states, driving datapath strobes and counting retired instructions.
module uc_multiciclo
   import uc_multiciclo_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic [3:0]       alu_flags,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             alu_src,
   output logic [3:0]       alu_cmd,
   output logic             rf_src,
   output logic             rf_we,
   output logic             d_mem_we,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t     state_q, state_d;
   logic       store_q;
   logic [1:0] alu_op;
   logic [3:0] dec_cmd;
   logic       dec_bad;
   logic       unused_flag;

   assign unused_flag = alu_flags[3];

   assign alu_op = (state_q == S_EXEC_R) ? ALU_OP_R  :
                   (state_q == S_EXEC_I) ? ALU_OP_I  :
                   (state_q == S_BRANCH) ? ALU_OP_BR : ALU_OP_ADD;

   uc_alu_decoder u_alu_decoder (
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .alu_op    (alu_op),
      .alu_cmd   (dec_cmd),
      .bad_funct (dec_bad)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Load/store choice is captured in DECODE so MEM_ADDR never looks at opcode.
   always_ff @(posedge clk) begin
      if (state_q == S_DECODE) store_q <= opcode[5];
   end

   always_comb begin
      state_d  = state_q;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 1'b0;
      alu_src  = 1'b0;
      alu_cmd  = ALU_ADD;
      rf_src   = 1'b0;
      rf_we    = 1'b0;
      d_mem_we = 1'b0;
      // Gating on rst_n makes strobes fall the moment reset asserts.
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end
            S_DECODE: begin
               case (opcode)
                  OP_R:               state_d = S_EXEC_R;
                  OP_I:               state_d = S_EXEC_I;
                  OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                  OP_BRANCH:          state_d = S_BRANCH;
                  OP_JAL:             state_d = S_JAL;
                  default:            state_d = S_TRAP;
               endcase
            end
            S_EXEC_R, S_EXEC_I: begin
               alu_src = (state_q == S_EXEC_I);
               alu_cmd = dec_cmd;
               if (dec_bad) begin
                  state_d = S_TRAP;
               end else begin
                  rf_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_MEM_ADDR: begin
               alu_src = 1'b1;
               state_d = store_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               alu_src = 1'b1;
               state_d = S_LD_WB;
            end
            S_LD_WB: begin
               rf_src  = 1'b1;
               rf_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_FETCH;
            end
            S_MEM_WR: begin
               d_mem_we = 1'b1;
               pc_we    = 1'b1;
               state_d  = S_FETCH;
            end
            S_BRANCH: begin
               alu_cmd = dec_cmd;
               if (dec_bad) begin
                  state_d = S_TRAP;
               end else begin
                  pc_we   = 1'b1;
                  pc_src  = branch_taken(funct3, alu_flags[2:0]);
                  state_d = S_FETCH;
               end
            end
            S_JAL: begin
               pc_src  = 1'b1;
               pc_we   = 1'b1;
               rf_we   = 1'b1;
               state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign illegal = (state_q == S_TRAP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired <= '0;
      else if (pc_we && (retired != {CNT_W{1'b1}}))
         retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: table of instructions with per-cycle strobe checks, plus
// trap, reset-mid-store and counter saturation sequences (narrow counter instance).
module tb_uc_multiciclo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic [3:0]  alu_flags;
   logic        ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, d_mem_we, illegal;
   logic [3:0]  alu_cmd;
   logic [31:0] retired;
   logic        unused_s_ir_we, unused_s_pc_we, unused_s_pc_src, unused_s_alu_src;
   logic        unused_s_rf_src, unused_s_rf_we, unused_s_d_mem_we, unused_s_illegal;
   logic [3:0]  unused_s_alu_cmd;
   logic [2:0]  s_retired;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_ret = 0;

   always #5 clk = ~clk;

   uc_multiciclo #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .alu_flags(alu_flags), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src(alu_src), .alu_cmd(alu_cmd), .rf_src(rf_src), .rf_we(rf_we),
      .d_mem_we(d_mem_we), .illegal(illegal), .retired(retired)
   );

   uc_multiciclo #(.CNT_W(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .alu_flags(alu_flags), .ir_we(unused_s_ir_we), .pc_we(unused_s_pc_we),
      .pc_src(unused_s_pc_src), .alu_src(unused_s_alu_src), .alu_cmd(unused_s_alu_cmd),
      .rf_src(unused_s_rf_src), .rf_we(unused_s_rf_we), .d_mem_we(unused_s_d_mem_we),
      .illegal(unused_s_illegal), .retired(s_retired)
   );

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [3:0] flags;
      int         lat;
      logic [3:0] cmd;
      logic       asrc;
      logic       rsrc;
      logic       rwe;
      logic       dwe;
      logic       psrc;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] sat3(input int n);
      sat3 = (n > 7) ? 32'd7 : n;
   endfunction

   // Entered at a falling edge; leaves at the falling edge after the commit cycle.
   task automatic run_instr(input vec_t v);
      opcode    = v.op;
      funct3    = v.f3;
      funct7_5  = v.f7;
      alu_flags = v.flags;
      for (int c = 0; c < v.lat; c++) begin
         #1;
         if (c == 0) begin
            check({v.name, " ir_we"}, {31'd0, ir_we}, 32'd1);
            check({v.name, " retired"}, retired, exp_ret);
            check({v.name, " sat_retired"}, {29'd0, s_retired}, sat3(exp_ret));
         end
         if (c < v.lat - 1) begin
            check({v.name, " early strobes"}, {29'd0, pc_we, rf_we, d_mem_we}, 32'd0);
         end else begin
            check({v.name, " pc_we"},    {31'd0, pc_we},    32'd1);
            check({v.name, " rf_we"},    {31'd0, rf_we},    {31'd0, v.rwe});
            check({v.name, " d_mem_we"}, {31'd0, d_mem_we}, {31'd0, v.dwe});
            check({v.name, " rf_src"},   {31'd0, rf_src},   {31'd0, v.rsrc});
            check({v.name, " pc_src"},   {31'd0, pc_src},   {31'd0, v.psrc});
            check({v.name, " alu_src"},  {31'd0, alu_src},  {31'd0, v.asrc});
            check({v.name, " alu_cmd"},  {28'd0, alu_cmd},  {28'd0, v.cmd});
         end
         @(negedge clk);
      end
      exp_ret++;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("reset illegal", {31'd0, illegal}, 32'd0);
      check("reset retired", retired, 32'd0);
      check("reset sat_retired", {29'd0, s_retired}, 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      exp_ret = 0;
   endtask

   initial begin
      logic saw_pc_we;
      vec_t add_v;

      vecs[0]  = '{"add",  7'b0110011, 3'b000, 1'b0, 4'b1000, 3, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{"sub",  7'b0110011, 3'b000, 1'b1, 4'b0000, 3, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{"and",  7'b0110011, 3'b111, 1'b0, 4'b0000, 3, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{"or",   7'b0110011, 3'b110, 1'b0, 4'b0000, 3, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{"addi", 7'b0010011, 3'b000, 1'b1, 4'b0000, 3, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{"andi", 7'b0010011, 3'b111, 1'b0, 4'b0000, 3, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{"ld",   7'b0000011, 3'b011, 1'b0, 4'b0000, 5, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{"sd",   7'b0100011, 3'b011, 1'b0, 4'b0000, 4, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{"beq_t",7'b1100011, 3'b000, 1'b0, 4'b0001, 3, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{"bne_n",7'b1100011, 3'b001, 1'b0, 4'b0001, 3, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{"blt_t",7'b1100011, 3'b100, 1'b0, 4'b0010, 3, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{"bge_t",7'b1100011, 3'b101, 1'b0, 4'b0110, 3, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{"blt_n",7'b1100011, 3'b100, 1'b0, 4'b0110, 3, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{"beq_n",7'b1100011, 3'b000, 1'b0, 4'b0000, 3, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{"jal",  7'b1101111, 3'b000, 1'b0, 4'b0000, 3, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      add_v = vecs[0];

      rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; alu_flags = 4'd0;
      #1;
      check("reset strobes",
            {24'd0, ir_we, pc_we, pc_src, alu_src, rf_src, rf_we, d_mem_we, illegal}, 32'd0);
      check("reset alu_cmd", {28'd0, alu_cmd}, 32'h2);
      check("reset retired", retired, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_instr(vecs[i]);
      #1;
      check("table retired", retired, 32'd15);
      check("table sat_retired", {29'd0, s_retired}, 32'd7);
      @(negedge clk);

      // Unsupported opcode: trap, counter frozen, inputs ignored
      opcode = 7'b1111111;
      repeat (2) @(negedge clk);
      #1;
      check("trap illegal", {31'd0, illegal}, 32'd1);
      opcode = 7'b0110011;
      saw_pc_we = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         saw_pc_we = saw_pc_we | pc_we | rf_we | d_mem_we | ir_we;
      end
      check("trap strobes", {31'd0, saw_pc_we}, 32'd0);
      check("trap illegal held", {31'd0, illegal}, 32'd1);
      check("trap retired frozen", retired, 32'd15);
      pulse_reset();

      // Bad R-type funct: no write, then trap
      opcode = 7'b0110011; funct3 = 3'b001; funct7_5 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("bad funct strobes", {30'd0, rf_we, pc_we}, 32'd0);
      @(negedge clk);
      #1;
      check("bad funct illegal", {31'd0, illegal}, 32'd1);
      pulse_reset();

      // Reset asserted in the middle of MEM_WR
      run_instr(add_v);
      opcode = 7'b0100011; funct3 = 3'b011;
      repeat (3) @(negedge clk);
      #1;
      check("mid-wr d_mem_we before", {31'd0, d_mem_we}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid-wr strobes drop", {29'd0, d_mem_we, pc_we, ir_we}, 32'd0);
      check("mid-wr retired", retired, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_ret = 0;
      #1;
      check("post-reset fetch", {31'd0, ir_we}, 32'd1);
      @(negedge clk);
      // rst_n release at the previous falling edge left FETCH in progress for one
      // cycle; re-align by running from a fresh reset.
      pulse_reset();
      run_instr(vecs[6]);

      // Narrow counter saturates at all-ones while the wide one keeps counting
      for (int i = 0; i < 8; i++) run_instr(add_v);
      #1;
      check("sat wide retired", retired, 32'd9);
      check("sat narrow retired", {29'd0, s_retired}, 32'd7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
